// File: rtl/fetch_stage.sv
// Instruction-fetch stage: fetch PC, imem request, F/D pipeline register, one-entry skid buffer, redirect handling.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter int unsigned    N        = 32,
  parameter logic [N-1:0]   RESET_PC = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           stall_d,
  input  logic           redirect_en,
  input  logic [N-1:0]   redirect_pc,
  output logic           imem_req,
  output logic [N-1:0]   imem_addr,
  input  logic           imem_ready,
  input  logic [N-1:0]   imem_rdata,
  output logic [N-1:0]   inst_d,
  output logic [N-1:0]   pc_d,
  output logic           valid_d,
  output logic [31:0]    perf_fetched,
  output logic [31:0]    perf_stall,
  output logic [1:0]     o_dbg_state
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  localparam logic [N-1:0] ALIGN_MASK = ~(N'(3));

  state_t       r_state, w_state_n;
  logic [N-1:0] r_pc_f, w_pc_f_n;
  logic [N-1:0] r_skid, w_skid_n;
  logic [N-1:0] r_tgt_q, w_tgt_q_n;
  logic [N-1:0] r_inst_d, w_inst_d_n;
  logic [N-1:0] r_pc_d, w_pc_d_n;
  logic         r_valid_d, w_valid_d_n;
  logic         w_xfer;
  logic [N-1:0] w_rpc;
  logic [N-1:0] w_pc_inc;

  // Handshake: a request transfers on a rising edge where imem_req && imem_ready;
  // imem_rdata is valid in that same cycle, and imem_req/imem_addr hold until it happens.
  assign imem_req    = (r_state != S_HOLD);
  assign imem_addr   = r_pc_f;
  assign w_xfer      = imem_req && imem_ready;
  assign w_rpc       = redirect_pc & ALIGN_MASK;
  assign w_pc_inc    = r_pc_f + N'(4);
  assign inst_d      = r_inst_d;
  assign pc_d        = r_pc_d;
  assign valid_d     = r_valid_d;
  assign o_dbg_state = r_state;

  always_comb begin
    w_state_n   = r_state;
    w_pc_f_n    = r_pc_f;
    w_skid_n    = r_skid;
    w_tgt_q_n   = r_tgt_q;
    w_inst_d_n  = r_inst_d;
    w_pc_d_n    = r_pc_d;
    w_valid_d_n = r_valid_d;
    unique case (r_state)
      S_FETCH: begin
        if (redirect_en) begin
          w_valid_d_n = 1'b0;
          if (w_xfer) begin
            w_pc_f_n = w_rpc;
          end else begin
            w_tgt_q_n = w_rpc;
            w_state_n = S_DISCARD;
          end
        end else if (w_xfer) begin
          w_pc_f_n = w_pc_inc;
          if (!stall_d) begin
            w_inst_d_n  = imem_rdata;
            w_pc_d_n    = w_pc_inc;
            w_valid_d_n = 1'b1;
          end else begin
            w_skid_n  = imem_rdata;
            w_state_n = S_HOLD;
          end
        end else if (!stall_d) begin
          w_valid_d_n = 1'b0;
        end
      end
      S_HOLD: begin
        // pc_f already points past the buffered word, so it is the decode-side pc.
        if (redirect_en) begin
          w_valid_d_n = 1'b0;
          w_pc_f_n    = w_rpc;
          w_state_n   = S_FETCH;
        end else if (!stall_d) begin
          w_inst_d_n  = r_skid;
          w_pc_d_n    = r_pc_f;
          w_valid_d_n = 1'b1;
          w_state_n   = S_FETCH;
        end
      end
      S_DISCARD: begin
        w_valid_d_n = 1'b0;
        if (redirect_en) begin
          w_tgt_q_n = w_rpc;
          if (w_xfer) begin
            w_pc_f_n  = w_rpc;
            w_state_n = S_FETCH;
          end
        end else if (w_xfer) begin
          w_pc_f_n  = r_tgt_q;
          w_state_n = S_FETCH;
        end
      end
      default: w_state_n = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_pc_f    <= RESET_PC;
      r_skid    <= '0;
      r_tgt_q   <= '0;
      r_inst_d  <= '0;
      r_pc_d    <= '0;
      r_valid_d <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_pc_f    <= w_pc_f_n;
      r_skid    <= w_skid_n;
      r_tgt_q   <= w_tgt_q_n;
      r_inst_d  <= w_inst_d_n;
      r_pc_d    <= w_pc_d_n;
      r_valid_d <= w_valid_d_n;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;
  logic        w_load;

  // A valid instruction enters F/D from either the memory (FETCH) or the skid (HOLD).
  assign w_load = !redirect_en && !stall_d &&
                  (((r_state == S_FETCH) && w_xfer) || (r_state == S_HOLD));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetched <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (w_load) r_perf_fetched <= r_perf_fetched + 32'd1;
      if (stall_d) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_stall   = r_perf_stall;
`else
  assign perf_fetched = '0;
  assign perf_stall   = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vectors with literal expectations plus a per-cycle
// comparison against a queue-based behavioural model of the fetch stage.
module tb_fetch_stage;

  localparam logic [1:0] ST_FETCH   = 2'd0;
  localparam logic [1:0] ST_HOLD    = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_d;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] inst_d;
  logic [31:0] pc_d;
  logic        valid_d;
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
  logic [1:0]  dbg_state;

  logic        ovr_en;
  logic [31:0] ovr_val;

  int checks   = 0;
  int failures = 0;

  fetch_stage #(.N(32), .RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_d      (stall_d),
    .redirect_en  (redirect_en),
    .redirect_pc  (redirect_pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .inst_d       (inst_d),
    .pc_d         (pc_d),
    .valid_d      (valid_d),
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall),
    .o_dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // Memory: returns the word address as data unless a directed value is forced.
  assign imem_rdata = ovr_en ? ovr_val : imem_addr;

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // exp_q holds fetched words still waiting to enter decode; m_drop marks an
  // outstanding request whose data must be thrown away, then fetch resumes at m_tgt.
  logic [31:0] exp_q[$];
  logic [31:0] m_pc, m_tgt, m_inst, m_pcd, m_fetched, m_stall;
  bit          m_valid, m_drop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_pc      = 32'h0;
      m_tgt     = 32'h0;
      m_inst    = 32'h0;
      m_pcd     = 32'h0;
      m_valid   = 1'b0;
      m_drop    = 1'b0;
      m_fetched = 32'h0;
      m_stall   = 32'h0;
    end else begin
      bit          req;
      bit          xfer;
      logic [31:0] rd;
      logic [31:0] rpc;
      req  = (exp_q.size() == 0);
      xfer = req && imem_ready;
      rd   = ovr_en ? ovr_val : m_pc;
      rpc  = {redirect_pc[31:2], 2'b00};
      if (stall_d) m_stall = m_stall + 1;
      if (redirect_en) begin
        m_valid = 1'b0;
        exp_q.delete();
        if (xfer) begin
          m_pc   = rpc;
          m_drop = 1'b0;
        end else if (req) begin
          m_drop = 1'b1;
          m_tgt  = rpc;
        end else begin
          m_pc = rpc;
        end
      end else if (m_drop) begin
        m_valid = 1'b0;
        if (xfer) begin
          m_pc   = m_tgt;
          m_drop = 1'b0;
        end
      end else if (exp_q.size() != 0) begin
        if (!stall_d) begin
          m_inst    = exp_q.pop_front();
          m_pcd     = m_pc;
          m_valid   = 1'b1;
          m_fetched = m_fetched + 1;
        end
      end else if (xfer) begin
        if (!stall_d) begin
          m_inst    = rd;
          m_pcd     = m_pc + 32'd4;
          m_valid   = 1'b1;
          m_fetched = m_fetched + 1;
        end else begin
          exp_q.push_back(rd);
        end
        m_pc = m_pc + 32'd4;
      end else if (!stall_d) begin
        m_valid = 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [1:0] st;
    st = (exp_q.size() != 0) ? ST_HOLD : (m_drop ? ST_DISCARD : ST_FETCH);
    chk("cyc_imem_req",  {31'd0, imem_req}, {31'd0, exp_q.size() == 0});
    chk("cyc_imem_addr", imem_addr, m_pc);
    chk("cyc_inst_d",    inst_d, m_inst);
    chk("cyc_pc_d",      pc_d, m_pcd);
    chk("cyc_valid_d",   {31'd0, valid_d}, {31'd0, m_valid});
    chk("cyc_state",     {30'd0, dbg_state}, {30'd0, st});
`ifdef FETCH_PERF_CNT_EN
    chk("cyc_perf_fetched", perf_fetched, m_fetched);
    chk("cyc_perf_stall",   perf_stall, m_stall);
`else
    chk("cyc_perf_fetched", perf_fetched, 32'h0);
    chk("cyc_perf_stall",   perf_stall, 32'h0);
`endif
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    stall_d     = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = 32'h0;
    imem_ready  = 1'b1;
    ovr_en      = 1'b0;
    ovr_val     = 32'h0;

    #3;
    chk("rst_req",   {31'd0, imem_req}, 32'd1);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_valid", {31'd0, valid_d}, 32'd0);
    chk("rst_inst",  inst_d, 32'h0);
    chk("rst_pc_d",  pc_d, 32'h0);
    #9 rst_n = 1'b1;

    // Zero-wait streaming from RESET_PC
    step(); chk("s1_inst", inst_d, 32'h0); chk("s1_pcd", pc_d, 32'h4);
            chk("s1_valid", {31'd0, valid_d}, 32'd1); chk("s1_addr", imem_addr, 32'h4);
    step(); chk("s2_inst", inst_d, 32'h4); chk("s2_pcd", pc_d, 32'h8);
    step(); chk("s3_inst", inst_d, 32'h8); chk("s3_pcd", pc_d, 32'hC);
            chk("s3_addr", imem_addr, 32'hC);
    step(); chk("s4_addr", imem_addr, 32'h10);

    // Stall while A5A5_0000 transfers at 0x10
    stall_d = 1'b1; ovr_en = 1'b1; ovr_val = 32'hA5A5_0000;
    step(); chk("hold_state", {30'd0, dbg_state}, {30'd0, ST_HOLD});
            chk("hold_req", {31'd0, imem_req}, 32'd0);
            chk("hold_inst", inst_d, 32'hC);
    step();
    step();
    stall_d = 1'b0; ovr_en = 1'b0;
    step(); chk("rel_inst", inst_d, 32'hA5A5_0000); chk("rel_pcd", pc_d, 32'h14);
            chk("rel_addr", imem_addr, 32'h14); chk("rel_req", {31'd0, imem_req}, 32'd1);
`ifdef FETCH_PERF_CNT_EN
            chk("rel_perf_stall", perf_stall, 32'd3); chk("rel_perf_fetched", perf_fetched, 32'd5);
`else
            chk("rel_perf_stall", perf_stall, 32'd0); chk("rel_perf_fetched", perf_fetched, 32'd0);
`endif
    repeat (3) step();
    chk("pre_disc_addr", imem_addr, 32'h20); chk("pre_disc_inst", inst_d, 32'h1C);

    // Redirect while the request at 0x20 is still waiting
    imem_ready = 1'b0; redirect_en = 1'b1; redirect_pc = 32'h100;
    step(); chk("disc_valid", {31'd0, valid_d}, 32'd0); chk("disc_addr", imem_addr, 32'h20);
            chk("disc_state", {30'd0, dbg_state}, {30'd0, ST_DISCARD});
    redirect_en = 1'b0;
    step(); chk("disc2_addr", imem_addr, 32'h20); chk("disc2_valid", {31'd0, valid_d}, 32'd0);
    imem_ready = 1'b1;
    step(); chk("disc3_addr", imem_addr, 32'h100); chk("disc3_valid", {31'd0, valid_d}, 32'd0);
            chk("disc3_inst", inst_d, 32'h1C);
    step(); chk("tgt_inst", inst_d, 32'h100); chk("tgt_pcd", pc_d, 32'h104);
            chk("tgt_valid", {31'd0, valid_d}, 32'd1);

    // Redirect from HOLD drops the skid entry; low address bits are ignored
    stall_d = 1'b1;
    step(); chk("h2_state", {30'd0, dbg_state}, {30'd0, ST_HOLD});
    redirect_en = 1'b1; redirect_pc = 32'h203;
    step(); chk("hr_valid", {31'd0, valid_d}, 32'd0); chk("hr_addr", imem_addr, 32'h200);
            chk("hr_req", {31'd0, imem_req}, 32'd1); chk("hr_inst", inst_d, 32'h100);
    redirect_en = 1'b0; stall_d = 1'b0;
    step(); chk("hr2_inst", inst_d, 32'h200); chk("hr2_pcd", pc_d, 32'h204);

    // Wrap at the top of the address space
    redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step(); chk("w_valid", {31'd0, valid_d}, 32'd0); chk("w_addr", imem_addr, 32'hFFFF_FFFC);
    redirect_en = 1'b0;
    step(); chk("w1_inst", inst_d, 32'hFFFF_FFFC); chk("w1_pcd", pc_d, 32'h0);
            chk("w1_addr", imem_addr, 32'h0);
    step(); chk("w2_inst", inst_d, 32'h0); chk("w2_pcd", pc_d, 32'h4);

    // Second redirect in DISCARD overwrites the target
    imem_ready = 1'b0; redirect_en = 1'b1; redirect_pc = 32'h500;
    step(); chk("ow_state", {30'd0, dbg_state}, {30'd0, ST_DISCARD}); chk("ow_addr", imem_addr, 32'h4);
    redirect_pc = 32'h540;
    step();
    redirect_en = 1'b0; imem_ready = 1'b1;
    step(); chk("ow2_addr", imem_addr, 32'h540); chk("ow2_state", {30'd0, dbg_state}, {30'd0, ST_FETCH});

    // Redirect coinciding with the dropped transfer in DISCARD
    imem_ready = 1'b0; redirect_en = 1'b1; redirect_pc = 32'h600;
    step();
    imem_ready = 1'b1; redirect_pc = 32'h680;
    step(); chk("dx_addr", imem_addr, 32'h680); chk("dx_state", {30'd0, dbg_state}, {30'd0, ST_FETCH});
    redirect_en = 1'b0;
    step(); chk("dx2_inst", inst_d, 32'h680); chk("dx2_pcd", pc_d, 32'h684);

    // Asynchronous reset in the middle of DISCARD
    imem_ready = 1'b0; redirect_en = 1'b1; redirect_pc = 32'h300;
    step(); chk("ar_pre_state", {30'd0, dbg_state}, {30'd0, ST_DISCARD});
    redirect_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'd0, valid_d}, 32'd0); chk("ar_addr", imem_addr, 32'h0);
    chk("ar_req", {31'd0, imem_req}, 32'd1); chk("ar_state", {30'd0, dbg_state}, {30'd0, ST_FETCH});
    chk("ar_perf_fetched", perf_fetched, 32'd0); chk("ar_perf_stall", perf_stall, 32'd0);
    step();
    rst_n = 1'b1; imem_ready = 1'b1;
    step(); chk("ar2_inst", inst_d, 32'h0); chk("ar2_pcd", pc_d, 32'h4);

    // Mixed stimulus; the per-cycle model comparison does the checking
    for (int i = 0; i < 80; i++) begin
      stall_d     = ($urandom_range(0, 2) == 0);
      imem_ready  = ($urandom_range(0, 3) != 0);
      redirect_en = ($urandom_range(0, 7) == 0);
      redirect_pc = $urandom();
      step();
    end
    stall_d = 1'b0; redirect_en = 1'b0; imem_ready = 1'b1;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
